// File: rtl/mlp_result_writer.sv
// rtl/mlp_result_writer.sv - MLP final-layer score writer with per-image argmax and done signalling
module mlp_result_writer #(
    parameter int IN_IMG_NUM       = 10,
    parameter int NUM_CLASS        = 10,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_DEPTH      = NUM_CLASS * IN_IMG_NUM * 4,
    localparam int AW              = $clog2(Y_BUF_DEPTH),
    localparam int IMG_W           = (IN_IMG_NUM > 1) ? $clog2(IN_IMG_NUM) : 1,
    localparam int CLS_W           = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        start_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic [Y_BUF_DATA_WIDTH-1:0] s_data_i,
    output logic                        y_buf_en,
    output logic                        y_buf_wr_en,
    output logic [AW-1:0]               y_buf_addr,
    output logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data,
    output logic                        pred_valid_o,
    output logic [3:0]                  pred_class_o,
    output logic [IMG_W-1:0]            pred_img_o,
    output logic                        busy_o,
    output logic                        done_intr_o,
    output logic                        done_led_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                              r_state;
    logic [CLS_W-1:0]                    r_cls;
    logic [IMG_W-1:0]                    r_img;
    logic [AW-1:0]                       r_addr_cnt;
    logic signed [Y_BUF_DATA_WIDTH-1:0]  r_max;
    logic [CLS_W-1:0]                    r_idx;

    logic                                r_y_buf_en;
    logic [AW-1:0]                       r_y_buf_addr;
    logic [Y_BUF_DATA_WIDTH-1:0]         r_y_buf_data;
    logic                                r_pred_valid;
    logic [3:0]                          r_pred_class;
    logic [IMG_W-1:0]                    r_pred_img;
    logic                                r_done_intr;
    logic                                r_done_led;

    logic                                w_run;
    logic                                w_accept;
    logic                                w_last_cls;
    logic                                w_last_img;
    logic signed [Y_BUF_DATA_WIDTH-1:0]  w_score;
    logic                                w_take;
    logic [CLS_W-1:0]                    w_best_idx;

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = s_valid_i & w_run;
    assign w_last_cls = (r_cls == CLS_W'(NUM_CLASS - 1));
    assign w_last_img = (r_img == IMG_W'(IN_IMG_NUM - 1));
    assign w_score    = $signed(s_data_i);

    // Strict greater-than keeps the lowest index on ties; class 0 always seeds the max.
    assign w_take     = (r_cls == '0) || (w_score > r_max);
    assign w_best_idx = w_take ? r_cls : r_idx;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_cls        <= '0;
            r_img        <= '0;
            r_addr_cnt   <= '0;
            r_max        <= '0;
            r_idx        <= '0;
            r_y_buf_en   <= 1'b0;
            r_y_buf_addr <= '0;
            r_y_buf_data <= '0;
            r_pred_valid <= 1'b0;
            r_pred_class <= '0;
            r_pred_img   <= '0;
            r_done_intr  <= 1'b0;
            r_done_led   <= 1'b0;
        end else begin
            r_y_buf_en   <= 1'b0;
            r_pred_valid <= 1'b0;
            r_done_intr  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_state    <= ST_RUN;
                        r_cls      <= '0;
                        r_img      <= '0;
                        r_addr_cnt <= '0;
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        r_y_buf_en   <= 1'b1;
                        r_y_buf_addr <= r_addr_cnt;
                        r_y_buf_data <= s_data_i;
                        r_addr_cnt   <= r_addr_cnt + AW'(4);

                        if (w_take) begin
                            r_max <= w_score;
                            r_idx <= r_cls;
                        end

                        if (w_last_cls) begin
                            r_cls        <= '0;
                            r_img        <= r_img + IMG_W'(1);
                            r_pred_valid <= 1'b1;
                            r_pred_class <= 4'(w_best_idx);
                            r_pred_img   <= r_img;
                            if (w_last_img) begin
                                r_state     <= ST_DONE;
                                r_done_intr <= 1'b1;
                                r_done_led  <= 1'b1;
                            end
                        end else begin
                            r_cls <= r_cls + CLS_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    // A restart here may coincide with the done pulse of the previous batch.
                    if (start_i) begin
                        r_state    <= ST_RUN;
                        r_cls      <= '0;
                        r_img      <= '0;
                        r_addr_cnt <= '0;
                        r_done_led <= 1'b0;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready_o    = w_run;
    assign busy_o       = w_run;
    assign y_buf_en     = r_y_buf_en;
    assign y_buf_wr_en  = r_y_buf_en;
    assign y_buf_addr   = r_y_buf_addr;
    assign y_buf_data   = r_y_buf_data;
    assign pred_valid_o = r_pred_valid;
    assign pred_class_o = r_pred_class;
    assign pred_img_o   = r_pred_img;
    assign done_intr_o  = r_done_intr;
    assign done_led_o   = r_done_led;

endmodule

// File: tb/tb_mlp_result_writer.sv
// tb/tb_mlp_result_writer.sv - directed self-checking bench for mlp_result_writer
module tb_mlp_result_writer;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [31:0] s_data_i = '0;
    logic        y_buf_en;
    logic        y_buf_wr_en;
    logic [8:0]  y_buf_addr;
    logic [31:0] y_buf_data;
    logic        pred_valid_o;
    logic [3:0]  pred_class_o;
    logic [3:0]  pred_img_o;
    logic        busy_o;
    logic        done_intr_o;
    logic        done_led_o;

    mlp_result_writer dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_i      (start_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .s_data_i     (s_data_i),
        .y_buf_en     (y_buf_en),
        .y_buf_wr_en  (y_buf_wr_en),
        .y_buf_addr   (y_buf_addr),
        .y_buf_data   (y_buf_data),
        .pred_valid_o (pred_valid_o),
        .pred_class_o (pred_class_o),
        .pred_img_o   (pred_img_o),
        .busy_o       (busy_o),
        .done_intr_o  (done_intr_o),
        .done_led_o   (done_led_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          pred_cls_q[$];
    int          pred_img_q[$];
    int          done_cnt  = 0;
    int          align_err = 0;
    logic [31:0] done_addr = '0;
    logic        done_en   = 1'b0;
    logic        prev_acc  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Observer samples on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (y_buf_en !== prev_acc) align_err++;
        if (y_buf_wr_en !== y_buf_en) align_err++;
        if (y_buf_en && y_buf_wr_en) begin
            wr_addr_q.push_back(32'(y_buf_addr));
            wr_data_q.push_back(y_buf_data);
        end
        if (pred_valid_o) begin
            pred_cls_q.push_back(int'(pred_class_o));
            pred_img_q.push_back(int'(pred_img_o));
        end
        if (done_intr_o) begin
            done_cnt++;
            done_addr = 32'(y_buf_addr);
            done_en   = y_buf_en;
        end
        prev_acc = rstn_i & s_valid_i & s_ready_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        pred_cls_q.delete();
        pred_img_q.delete();
        done_cnt  = 0;
        align_err = 0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] v, input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        s_valid_i = 1'b0;
        repeat (g) tick();
        s_valid_i = 1'b1;
        s_data_i  = v;
        tick();
        s_valid_i = 1'b0;
    endtask

    task automatic verify_seq(input string tag, input int n, input bit chk_data);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= wr_addr_q.size()) bad++;
            else begin
                if (wr_addr_q[i] != 32'(4 * i)) bad++;
                if (chk_data && wr_data_q[i] != 32'(i)) bad++;
            end
        end
        check({tag, "_seq_errors"}, 64'(bad), 64'd0);
    endtask

    task automatic verify_preds(input string tag, input int first_img);
        int bad;
        bad = 0;
        if (pred_cls_q.size() != 10) bad++;
        for (int i = first_img; i < 10 && i < pred_cls_q.size(); i++) begin
            if (pred_cls_q[i] != 9 || pred_img_q[i] != i) bad++;
        end
        check({tag, "_pred_errors"}, 64'(bad), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] img0 [10];
        img0 = '{32'd5, -32'sd3, 32'd7, 32'd7, -32'sd100, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};

        // Reset and idle behaviour
        repeat (3) tick();
        check("rst_ready", 64'(s_ready_o), 0);
        check("rst_outs", 64'({y_buf_en, y_buf_wr_en, y_buf_addr, y_buf_data, pred_valid_o,
                               pred_class_o, pred_img_o, busy_o, done_intr_o, done_led_o}), 0);
        rstn_i = 1'b1;
        tick();
        clear_mon();
        s_valid_i = 1'b1;
        s_data_i  = 32'd55;
        repeat (5) tick();
        check("idle_ready", 64'(s_ready_o), 0);
        s_valid_i = 1'b0;
        tick();
        check("idle_writes", 64'(wr_addr_q.size()), 0);

        // Back-to-back batch, value = beat index
        clear_mon();
        do_start();
        check("run_busy", 64'(busy_o), 1);
        for (int n = 0; n < 100; n++) send(32'(n), 0);
        repeat (3) tick();
        check("b2b_count", 64'(wr_addr_q.size()), 100);
        verify_seq("b2b", 100, 1'b1);
        check("b2b_last_addr", 64'(wr_addr_q[99]), 396);
        verify_preds("b2b", 0);
        check("b2b_done_cnt", 64'(done_cnt), 1);
        check("b2b_done_addr", 64'(done_addr), 396);
        check("b2b_done_with_wr", 64'(done_en), 1);
        check("b2b_led", 64'(done_led_o), 1);
        check("b2b_busy_off", 64'(busy_o), 0);
        check("b2b_align", 64'(align_err), 0);

        // Restart from DONE, argmax corner values, start held during RUN
        clear_mon();
        do_start();
        check("restart_led_clr", 64'(done_led_o), 0);
        for (int n = 0; n < 100; n++) begin
            logic [31:0] v;
            if (n < 10) v = img0[n];
            else if (n < 20) v = 32'hFFFF_FFFF;
            else if (n == 20) v = 32'h8000_0000;
            else if (n == 21) v = 32'h7FFF_FFFF;
            else if (n < 30) v = 32'd0;
            else v = 32'(n);
            start_i = (n >= 30 && n < 40);
            send(v, 0);
        end
        start_i = 1'b0;
        repeat (3) tick();
        check("arg_count", 64'(wr_addr_q.size()), 100);
        verify_seq("arg", 100, 1'b0);
        check("arg_img0_tie", 64'(pred_cls_q[0]), 2);
        check("arg_img1_allneg", 64'(pred_cls_q[1]), 0);
        check("arg_img2_extremes", 64'(pred_cls_q[2]), 1);
        check("arg_img3", 64'(pred_cls_q[3]), 9);
        check("arg_img9_idx", 64'(pred_img_q[9]), 9);
        check("arg_data_21", 64'(wr_data_q[21]), 64'h7FFF_FFFF);
        check("arg_done_cnt", 64'(done_cnt), 1);

        // Random valid gaps, then restart in the cycle done_intr_o is high
        clear_mon();
        do_start();
        for (int n = 0; n < 100; n++) send(32'(n), 2);
        start_i = 1'b1;
        check("gap_done_same_cycle", 64'(done_intr_o), 1);
        tick();
        start_i = 1'b0;
        check("gap_led_clr", 64'(done_led_o), 0);
        send(32'd77, 0);
        repeat (2) tick();
        check("gap_count", 64'(wr_addr_q.size()), 101);
        verify_seq("gap", 100, 1'b1);
        check("gap_align", 64'(align_err), 0);
        check("gap_restart_addr", 64'(wr_addr_q[100]), 0);
        check("gap_restart_data", 64'(wr_data_q[100]), 77);
        check("gap_done_cnt", 64'(done_cnt), 1);

        // Mid-batch reset after beat 37, then a clean batch
        rstn_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        tick();
        clear_mon();
        do_start();
        for (int n = 0; n < 38; n++) send(32'(n), 0);
        #6;
        rstn_i = 1'b0;
        #2;
        check("mid_rst_outs", 64'({y_buf_en, y_buf_addr, y_buf_data, pred_valid_o, pred_class_o,
                                   pred_img_o, busy_o, s_ready_o, done_intr_o, done_led_o}), 0);
        repeat (2) tick();
        rstn_i = 1'b1;
        repeat (4) tick();
        check("mid_rst_writes", 64'(wr_addr_q.size()), 38);
        check("mid_rst_no_done", 64'(done_cnt), 0);
        check("mid_rst_idle", 64'(busy_o), 0);
        clear_mon();
        do_start();
        for (int n = 0; n < 100; n++) send(32'(n), 0);
        repeat (3) tick();
        check("post_rst_first_addr", 64'(wr_addr_q[0]), 0);
        verify_seq("post_rst", 100, 1'b1);
        verify_preds("post_rst", 0);
        check("post_rst_done_cnt", 64'(done_cnt), 1);
        check("post_rst_led", 64'(done_led_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
